mult_accum: RTL and testbench

Downstream accumulation stage for the pipelined 11x8 signed multiplier. It consumes the 19-bit signed product stream, re-aligns framing side-band with the multiplier's fixed latency, and sums products over a frame delimited by `op_last`. Completed sums are presented on a valid/ready output register, along with a per-frame saturation flag and a product count. Together the two blocks form a streaming MAC for dot-products and FIR taps.

---
 rtl/mult_accum.sv | 156 +++++++++++++++
 tb/tb_mult_accum.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// mult_accum: frame accumulator that follows the pipelined 11x8 signed multiplier.
// It delays the operand framing bits to line up with the product stream, sums the
// products of each frame with saturation, and presents each completed frame on a
// valid/ready output register. A completed frame that finds the output register
// still occupied is dropped and flagged on the sticky overrun bit.
module mult_accum #(
  parameter int MULT_LAT = 8,   // multiplier latency, must be >= 2
  parameter int PROD_W   = 19,
  parameter int ACC_W    = 24,  // must be > PROD_W
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_last,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_sat,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overrun
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t              state_r;
  logic [MULT_LAT-1:0] dl_valid_r;
  logic [MULT_LAT-1:0] dl_last_r;
  logic [ACC_W-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                sat_r;

  logic                p_valid_s;
  logic                p_last_s;
  logic                done_s;
  logic [ACC_W-1:0]    base_s;
  logic                base_sat_s;
  logic [ACC_W-1:0]    sum_s;
  logic                add_ovf_s;
  logic                sum_sat_s;
  logic [CNT_W-1:0]    cnt_next_s;

  // Saturating add of a sign-extended product onto the accumulator.
  // Returns {clamped, result}; the sum is formed one bit wider than the
  // accumulator so that overflow shows up as disagreeing top two bits.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] wide;
    logic [ACC_W:0] res;
    wide = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) begin
        res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};  // most negative value
      end else begin
        res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};  // most positive value
      end
    end else begin
      res = {1'b0, wide[ACC_W-1:0]};
    end
    return res;
  endfunction

  // The delay-line tap is the framing for the product arriving this cycle.
  assign p_valid_s = dl_valid_r[MULT_LAT-1];
  assign p_last_s  = dl_last_r[MULT_LAT-1];
  assign done_s    = p_valid_s & p_last_s;

  // Delay operand framing by the multiplier latency; reset drops in-flight operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_valid_r <= {MULT_LAT{1'b0}};
      dl_last_r  <= {MULT_LAT{1'b0}};
    end else begin
      dl_valid_r <= {dl_valid_r[MULT_LAT-2:0], op_valid};
      dl_last_r  <= {dl_last_r[MULT_LAT-2:0], op_valid & op_last};
    end
  end

  // Next sum, count and sat flag: a new frame starts from zero, an open frame continues.
  always_comb begin
    base_s     = {ACC_W{1'b0}};
    base_sat_s = 1'b0;
    cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_r)
      ST_IDLE: begin
        base_s     = {ACC_W{1'b0}};
        base_sat_s = 1'b0;
        cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ST_ACCUM: begin
        base_s     = acc_r;
        base_sat_s = sat_r;
        if (&cnt_r) begin
          cnt_next_s = cnt_r;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        base_s     = {ACC_W{1'b0}};
        base_sat_s = 1'b0;
        cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end
    endcase
    {add_ovf_s, sum_s} = sat_add(base_s, product);
    sum_sat_s = base_sat_s | add_ovf_s;
  end

  // Frame FSM with the accumulator and the valid/ready output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      sat_r     <= 1'b0;
      acc_out   <= {ACC_W{1'b0}};
      acc_cnt   <= {CNT_W{1'b0}};
      acc_sat   <= 1'b0;
      acc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (p_valid_s) begin
        if (p_last_s) begin
          state_r <= ST_IDLE;
          acc_r   <= {ACC_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
          sat_r   <= 1'b0;
        end else begin
          state_r <= ST_ACCUM;
          acc_r   <= sum_s;
          cnt_r   <= cnt_next_s;
          sat_r   <= sum_sat_s;
        end
      end

      if (done_s) begin
        if (acc_valid && !acc_ready) begin
          // Held result has priority; the new frame is lost.
          overrun <= 1'b1;
        end else begin
          acc_out   <= sum_s;
          acc_cnt   <= cnt_next_s;
          acc_sat   <= sum_sat_s;
          acc_valid <= 1'b1;
        end
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Testbench for mult_accum: models the 8-cycle multiplier in front of the DUT,
// pushes expected frame results to a scoreboard as frames are driven and
// compares them against results collected on each output handshake.
module tb_mult_accum;

  localparam int MULT_LAT = 8;
  localparam int PROD_W   = 19;
  localparam int ACC_W    = 24;
  localparam int CNT_W    = 8;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  b;
  } op_t;

  typedef struct packed {
    logic [ACC_W-1:0] out;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              op_valid;
  logic              op_last;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_sat;
  logic              acc_valid;
  logic              acc_ready;
  logic              overrun;

  op_t               ops[$];
  res_t              sb_q[$];
  res_t              rx_q[$];
  logic [PROD_W-1:0] hist [MULT_LAT];
  int                n_checks = 0;
  int                n_fail   = 0;

  mult_accum #(
    .MULT_LAT(MULT_LAT), .PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last),
    .product(product), .acc_out(acc_out), .acc_cnt(acc_cnt), .acc_sat(acc_sat),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [PROD_W-1:0] mul(input op_t op);
    logic signed [PROD_W-1:0] p;
    p = $signed(op.a) * $signed(op.b);
    return p;
  endfunction

  // One clock: multiplier model output, operand drive, handshake capture.
  task automatic step(input logic v, input logic l, input op_t op, input logic rdy);
    res_t r;
    product = hist[MULT_LAT-1];
    for (int i = MULT_LAT-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v ? mul(op) : PROD_W'($urandom);
    op_valid  = v;
    op_last   = l;
    acc_ready = rdy;
    if (acc_valid && rdy) begin
      r.out = acc_out; r.cnt = acc_cnt; r.sat = acc_sat;
      rx_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 1'b0, '0, rdy);
  endtask

  // Drive all queued operands as one frame and push the expected result.
  task automatic send_frame(input logic rdy);
    longint s = 0;
    int c = 0;
    logic sat = 1'b0;
    logic signed [PROD_W-1:0] p;
    res_t r;
    foreach (ops[i]) begin
      p = mul(ops[i]);
      s = s + p;
      if (s > MAXV) begin s = MAXV; sat = 1'b1; end
      else if (s < MINV) begin s = MINV; sat = 1'b1; end
      else begin s = s; end
      if (c < 255) c++;
      step(1'b1, i == ops.size()-1, ops[i], rdy);
    end
    r.out = s[ACC_W-1:0]; r.cnt = c[CNT_W-1:0]; r.sat = sat;
    sb_q.push_back(r);
    ops.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op_last = 1'b0; acc_ready = 1'b0; product = '0;
    for (int i = 0; i < MULT_LAT; i++) hist[i] = '0;
    @(posedge clk); #1;
    n_checks++;
    if ({acc_out, acc_cnt, acc_sat, acc_valid, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%0d cnt=%0d sat=%0b valid=%0b ovr=%0b, expected all 0",
               acc_out, acc_cnt, acc_sat, acc_valid, overrun);
    end
    idle(2, 1'b0);
    rst = 1'b0;
    idle(2, 1'b0);
    n_checks++;
    if (acc_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_valid: got %0b expected 0", acc_valid);
    end
  endtask

  task automatic test_basic;
    int edges, first, vcyc;
    res_t got, exp;
    ops.push_back('{11'sd3, 8'sd5});
    ops.push_back('{-11'sd2, 8'sd7});
    ops.push_back('{11'sd100, -8'sd4});
    send_frame(1'b1);
    edges = 1; first = -1; vcyc = 0;
    for (int n = 0; n < 12; n++) begin
      if (acc_valid === 1'b1) begin
        vcyc++;
        if (first < 0) first = edges;
      end
      step(1'b0, 1'b0, '0, 1'b1);
      edges++;
    end
    n_checks++;
    if (first != 9) begin
      n_fail++; $display("FAIL basic_latency: valid after edge %0d, expected 9", first);
    end
    n_checks++;
    if (vcyc != 1) begin
      n_fail++; $display("FAIL basic_valid_width: high %0d cycles, expected 1", vcyc);
    end
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL basic_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  task automatic test_saturate;
    res_t got, exp;
    for (int i = 0; i < 64; i++) ops.push_back('{-11'sd1024, -8'sd128});
    send_frame(1'b1);
    ops.push_back('{11'sd1, 8'sd1});
    send_frame(1'b1);
    for (int i = 0; i < 65; i++) ops.push_back('{-11'sd1024, 8'sd127});
    send_frame(1'b1);
    idle(12, 1'b1);
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sat_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  task automatic test_zero_and_count;
    res_t got, exp;
    ops.push_back('{11'sd0, 8'sd55});
    ops.push_back('{-11'sd9, 8'sd0});
    ops.push_back('{11'sd0, 8'sd0});
    send_frame(1'b1);
    for (int i = 0; i < 300; i++) ops.push_back('{11'sd1, 8'sd1});
    send_frame(1'b1);
    idle(12, 1'b1);
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL zero_cnt_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_cnt_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    int vcyc;
    res_t got, exp;
    ops.push_back('{11'sd1, 8'sd1}); send_frame(1'b1);
    ops.push_back('{11'sd2, 8'sd2}); send_frame(1'b1);
    vcyc = 0;
    for (int n = 0; n < 12; n++) begin
      if (acc_valid === 1'b1) vcyc++;
      step(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++;
    if (vcyc != 2) begin
      n_fail++; $display("FAIL b2b_valid_cycles: %0d, expected 2", vcyc);
    end
    // Second pass: ready rises only once the first result is visible,
    // which is the cycle the second frame completes.
    ops.push_back('{11'sd1, 8'sd1}); send_frame(1'b0);
    ops.push_back('{11'sd2, 8'sd2}); send_frame(1'b0);
    vcyc = 0;
    for (int n = 0; n < 12; n++) begin
      if (acc_valid === 1'b1) vcyc++;
      step(1'b0, 1'b0, '0, acc_valid);
    end
    n_checks++;
    if (vcyc != 2) begin
      n_fail++; $display("FAIL b2b_hold_valid_cycles: %0d, expected 2", vcyc);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overrun: got %0b expected 0", overrun);
    end
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  task automatic test_overrun;
    res_t got, exp;
    ops.push_back('{11'sd2, 8'sd3}); send_frame(1'b0);
    idle(1, 1'b0);
    ops.push_back('{11'sd4, 8'sd5}); send_frame(1'b0);
    void'(sb_q.pop_back());  // second frame is dropped while the first is held
    idle(10, 1'b0);
    n_checks++;
    if ({acc_valid, overrun} !== 2'b11 || $signed(acc_out) !== 24'sd6) begin
      n_fail++;
      $display("FAIL ovr_hold: valid=%0b ovr=%0b out=%0d, expected valid=1 ovr=1 out=6",
               acc_valid, overrun, $signed(acc_out));
    end
    idle(1, 1'b1);
    n_checks++;
    if ({acc_valid, overrun} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_sticky: valid=%0b ovr=%0b, expected valid=0 ovr=1", acc_valid, overrun);
    end
    idle(2, 1'b1);
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ovr_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  task automatic test_abort;
    res_t got, exp;
    step(1'b1, 1'b0, '{11'sd10, 8'sd10}, 1'b1);
    step(1'b1, 1'b0, '{11'sd10, 8'sd10}, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({acc_out, acc_cnt, acc_sat, acc_valid, overrun} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset_outputs: out=%0d cnt=%0d sat=%0b valid=%0b ovr=%0b, expected all 0",
               acc_out, acc_cnt, acc_sat, acc_valid, overrun);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    rst = 1'b0;
    ops.push_back('{11'sd7, -8'sd3}); send_frame(1'b1);
    idle(12, 1'b1);
    while (rx_q.size() > 0 && sb_q.size() > 0) begin
      got = rx_q.pop_front(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_result: got out=%0d cnt=%0d sat=%0b, expected out=%0d cnt=%0d sat=%0b",
                 $signed(got.out), got.cnt, got.sat, $signed(exp.out), exp.cnt, exp.sat);
      end
    end
    n_checks++;
    if (rx_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_count: %0d unexpected results, %0d missing", rx_q.size(), sb_q.size());
      rx_q.delete(); sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_zero_and_count();
    test_back_to_back();
    test_overrun();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
